// File: rtl/inert_spi_seq.sv
// -----------------------------------------------------------------------------
// inert_spi_seq
//   SPI transaction sequencer for the inertial sensor path. After reset it
//   waits out the sensor power-up time and writes the gyro configuration
//   table. It then services the data-ready INT line with two yaw register
//   reads and assembles a signed 16-bit yaw rate.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   INT        gyro data-ready (asynchronous, active high)
//   done       SPI_mnrch transaction-complete pulse, resp valid
//   resp       SPI_mnrch returned word, read data in [7:0]
//   snd        one-cycle pulse starting a SPI transaction
//   cmd        SPI command word, stable from snd until done
//   yaw_rt     assembled yaw rate {high byte, low byte}
//   vld        one-cycle pulse, yaw_rt updated
//   init_done  sticky flag, configuration table written
// -----------------------------------------------------------------------------
module inert_spi_seq #(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] resp,
  output logic        snd,
  output logic [15:0] cmd,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        init_done
);

  typedef enum logic [2:0] {
    RST_WAIT, CFG, CFG_WAIT, IDLE, RD_L, RD_L_WAIT, RD_H, RD_H_WAIT
  } state_t;

  localparam logic [15:0] RD_L_CMD = 16'hA600;
  localparam logic [15:0] RD_H_CMD = 16'hA700;

  state_t      state, nxt;
  logic [15:0] tmr;
  logic        tmr_exp;
  logic [1:0]  idx, idx_nxt;
  logic        INT_ff1, INT_ff2;
  logic [7:0]  low_byte;
  logic        snd_nxt;
  logic [15:0] cmd_nxt;

  function automatic logic [15:0] cfg_word(input logic [1:0] i);
    case (i)
      2'd0:    cfg_word = 16'h0D02;  // INT enable on data ready
      2'd1:    cfg_word = 16'h1053;  // accel ODR
      2'd2:    cfg_word = 16'h1150;  // gyro ODR
      default: cfg_word = 16'h1460;  // rounding
    endcase
  endfunction

  assign tmr_exp = FAST_SIM ? (&tmr[8:0]) : (&tmr);

  // INT is asynchronous to clk; only the second flop is ever observed.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      INT_ff1 <= 1'b0;
      INT_ff2 <= 1'b0;
    end else begin
      INT_ff1 <= INT;
      INT_ff2 <= INT_ff1;
    end

  // Power-up timer: runs only while waiting, freezes at expiry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                          tmr <= '0;
    else if (state == RST_WAIT && !tmr_exp) tmr <= tmr + 16'd1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RST_WAIT;
      idx   <= '0;
    end else begin
      state <= nxt;
      idx   <= idx_nxt;
    end

  always_comb begin
    nxt     = state;
    idx_nxt = idx;
    case (state)
      RST_WAIT:  if (tmr_exp) nxt = CFG;
      CFG:       nxt = CFG_WAIT;
      CFG_WAIT:
        if (done) begin
          if (idx != 2'd3) begin
            idx_nxt = idx + 2'd1;
            nxt     = CFG;
          end else begin
            nxt = IDLE;
          end
        end
      IDLE:      if (INT_ff2) nxt = RD_L;
      RD_L:      nxt = RD_L_WAIT;
      RD_L_WAIT: if (done) nxt = RD_H;
      RD_H:      nxt = RD_H_WAIT;
      RD_H_WAIT: if (done) nxt = IDLE;
      default:   nxt = RST_WAIT;
    endcase
  end

  // snd/cmd are decoded from the next state and registered, so snd is high
  // exactly for the single cycle spent in CFG/RD_L/RD_H and cmd only changes
  // when a new transaction starts.
  always_comb begin
    snd_nxt = 1'b0;
    cmd_nxt = cmd;
    case (nxt)
      CFG:     begin snd_nxt = 1'b1; cmd_nxt = cfg_word(idx_nxt); end
      RD_L:    begin snd_nxt = 1'b1; cmd_nxt = RD_L_CMD;          end
      RD_H:    begin snd_nxt = 1'b1; cmd_nxt = RD_H_CMD;          end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      snd <= 1'b0;
      cmd <= 16'h0000;
    end else begin
      snd <= snd_nxt;
      cmd <= cmd_nxt;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      low_byte  <= 8'h00;
      yaw_rt    <= 16'h0000;
      vld       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      vld <= 1'b0;
      if (state == RD_L_WAIT && done) low_byte <= resp[7:0];
      if (state == RD_H_WAIT && done) begin
        yaw_rt <= {resp[7:0], low_byte};
        vld    <= 1'b1;
      end
      if (state == CFG_WAIT && done && idx == 2'd3) init_done <= 1'b1;
    end

endmodule

// File: tb/tb_inert_spi_seq.sv
module tb_inert_spi_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] resp = 16'h0000;
  logic        snd;
  logic [15:0] cmd;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        init_done;

  always #5 clk = ~clk;

  inert_spi_seq #(.FAST_SIM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .resp(resp),
    .snd(snd), .cmd(cmd), .yaw_rt(yaw_rt), .vld(vld), .init_done(init_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard queues: filled when stimulus is driven, drained by the monitor.
  logic [15:0] cmd_q[$];
  logic [15:0] yaw_q[$];
  bit outst = 1'b0;
  int snd_cnt = 0;
  int vld_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) outst = 1'b0;
    else begin
      if (snd) begin
        snd_cnt++;
        chk("snd_while_busy", outst, 0);
        if (cmd_q.size() == 0) chk("extra_snd", snd, 0);
        else chk("cmd", cmd, cmd_q.pop_front());
        outst = 1'b1;
      end
      if (done) outst = 1'b0;
      if (vld) begin
        vld_cnt++;
        if (yaw_q.size() == 0) chk("extra_vld", vld, 0);
        else chk("yaw_rt", yaw_rt, yaw_q.pop_front());
      end
    end
  end

  task automatic wait_snd(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (snd) begin ok = 1'b1; break; end
    end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  // Return done 8 clocks later; exits 1ns after the edge that samples done.
  task automatic respond(input logic [15:0] r);
    repeat (8) @(posedge clk);
    #1 resp = r; done = 1'b1;
    @(posedge clk);
    #1 done = 1'b0;
  endtask

  task automatic read_tail(input logic [15:0] lo, input logic [15:0] hi, input bit drop);
    respond(lo);
    if (drop) INT = 1'b0;
    wait_snd("rd_h");
    respond(hi);
    @(negedge clk); chk("vld_hi", vld, 1);
    @(negedge clk); chk("vld_lo", vld, 0);
  endtask

  task automatic do_read(input logic [15:0] lo, input logic [15:0] hi,
                         input logic [15:0] yaw, input logic [15:0] prev);
    cmd_q.push_back(16'hA600);
    cmd_q.push_back(16'hA700);
    yaw_q.push_back(yaw);
    INT = 1'b1;
    wait_snd("rd_l");
    chk("yaw_hold", yaw_rt, prev);
    read_tail(lo, hi, 1'b1);
  endtask

  task automatic powerup(input string nm);
    int k;
    k = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (i == 5) done = 1'b1;      // spurious done during the wait
      if (i == 6) done = 1'b0;
      if (snd) begin k = i; break; end
    end
    chk(nm, k, 512);
  endtask

  task automatic config_seq;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) wait_snd("cfg");
      if (c == 3) chk("init_done_before", init_done, 0);
      respond(16'h0000);
    end
    @(negedge clk);
    chk("init_done_rise", init_done, 1);
    chk("snd_at_init", snd, 0);
  endtask

  task automatic push_cfg;
    cmd_q.push_back(16'h0D02);
    cmd_q.push_back(16'h1053);
    cmd_q.push_back(16'h1150);
    cmd_q.push_back(16'h1460);
  endtask

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [15:0] yaw;
  } vec_t;

  vec_t vecs[4];
  logic [15:0] prev;
  int s0, v0;

  initial begin
    // upper resp bytes carry junk to prove only [7:0] is used
    vecs[0] = '{16'hFF34, 16'h0012, 16'h1234};
    vecs[1] = '{16'hAB80, 16'hCDFF, 16'hFF80};
    vecs[2] = '{16'h0000, 16'h0080, 16'h8000};
    vecs[3] = '{16'h12FF, 16'h347F, 16'h7FFF};

    repeat (3) @(negedge clk);
    chk("rst_snd", snd, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_yaw", yaw_rt, 0);
    chk("rst_vld", vld, 0);
    chk("rst_init", init_done, 0);

    push_cfg();
    cmd_q.push_back(16'hA600);
    cmd_q.push_back(16'hA700);
    yaw_q.push_back(16'h6611);
    rst_n = 1'b1;
    powerup("powerup_cycles");
    INT = 1'b1;                       // held off until configuration finishes
    config_seq();
    @(negedge clk);
    chk("a600_after_init", snd, 1);
    read_tail(16'h5511, 16'h0066, 1'b1);
    prev = 16'h6611;

    foreach (vecs[i]) begin
      do_read(vecs[i].lo, vecs[i].hi, vecs[i].yaw, prev);
      prev = vecs[i].yaw;
    end

    // back-to-back: INT stays high, new read starts right after vld
    cmd_q.push_back(16'hA600); cmd_q.push_back(16'hA700); yaw_q.push_back(16'h2143);
    cmd_q.push_back(16'hA600); cmd_q.push_back(16'hA700); yaw_q.push_back(16'h6587);
    INT = 1'b1;
    wait_snd("b2b_first");
    read_tail(16'h0043, 16'h0021, 1'b0);
    chk("b2b_snd", snd, 1);
    read_tail(16'h0087, 16'h0065, 1'b1);

    // spurious done in IDLE
    s0 = snd_cnt; v0 = vld_cnt;
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_done_snd", snd_cnt - s0, 0);
    chk("idle_done_vld", vld_cnt - v0, 0);
    chk("idle_done_yaw", yaw_rt, 16'h6587);

    // reset in RD_H_WAIT
    cmd_q.push_back(16'hA600); cmd_q.push_back(16'hA700);
    INT = 1'b1;
    wait_snd("rst_rd_l");
    respond(16'h0099);
    INT = 1'b0;
    wait_snd("rst_rd_h");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_snd", snd, 0);
    chk("mid_rst_cmd", cmd, 0);
    chk("mid_rst_yaw", yaw_rt, 0);
    chk("mid_rst_vld", vld, 0);
    chk("mid_rst_init", init_done, 0);
    cmd_q.delete();
    yaw_q.delete();
    push_cfg();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    powerup("repowerup_cycles");
    config_seq();
    do_read(16'h00CD, 16'h00AB, 16'hABCD, 16'h0000);
    repeat (5) @(negedge clk);
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("yaw_q_empty", yaw_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
